fp16_to_fixed: RTL and testbench

Streaming converter from IEEE-754 binary16 to signed two's-complement fixed point. It is the decode-side counterpart of the fp16 adder in the hidden-neuron datapath. It takes fp16 neuron sums and emits saturated Q(OUT_W-FRAC_W).FRAC_W integers for the fixed-point activation stage. It is a 2-stage pipeline with a valid/ready handshake and backpressure, and it also provides NaN/saturation flags and a saturation event counter.

---
 rtl/fp16_pkg.sv | 23 ++
 rtl/fp16_to_fixed_if.sv | 31 +++
 rtl/fp16_unpack.sv | 39 +++
 rtl/fp16_to_fixed.sv | 170 +++++++++++++++++
 tb/tb_fp16_to_fixed.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/fp16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp16_pkg
// Brief    : Shared IEEE-754 binary16 constants and operand classification.
// Revision : 1.0
// ============================================================================
package fp16_pkg;

    localparam int FP16_BIAS    = 15;
    localparam int FP16_EXP_W   = 5;
    localparam int FP16_FRAC_W  = 10;
    localparam int FP16_EXP_MAX = 31;

    typedef enum logic [2:0] {
        ZERO    = 3'd0,
        SUBNORM = 3'd1,
        NORMAL  = 3'd2,
        INF     = 3'd3,
        NAN     = 3'd4
    } fp16_class_t;

endpackage : fp16_pkg
`default_nettype wire

// File: rtl/fp16_to_fixed_if.sv
`default_nettype none
// ============================================================================
// Module   : fp16_to_fixed_if
// Brief    : Stream, flag and counter signals of the fp16 to fixed converter.
// Revision : 1.0
// ============================================================================
interface fp16_to_fixed_if #(
    parameter int OUT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;
    logic             out_nan;
    logic [15:0]      sat_cnt;
    logic             sat_clr;

    modport slave (
        input  in_valid, in_data, out_ready, sat_clr,
        output in_ready, out_valid, out_data, out_sat, out_nan, sat_cnt
    );

    modport master (
        output in_valid, in_data, out_ready, sat_clr,
        input  in_ready, out_valid, out_data, out_sat, out_nan, sat_cnt
    );
endinterface : fp16_to_fixed_if
`default_nettype wire

// File: rtl/fp16_unpack.sv
`default_nettype none
// ============================================================================
// Module   : fp16_unpack
// Brief    : Combinational fp16 classification with mantissa/exponent extract.
// Revision : 1.0
// ============================================================================
module fp16_unpack
    import fp16_pkg::*;
(
    input  wire logic [15:0] i_data,
    output fp16_class_t      o_cls,
    output logic             o_sign,
    output logic [10:0]      o_mant,
    output logic [4:0]       o_exp
);

    logic [FP16_EXP_W-1:0]  w_exp;
    logic [FP16_FRAC_W-1:0] w_frac;

    assign w_exp  = i_data[14:10];
    assign w_frac = i_data[9:0];
    assign o_sign = i_data[15];

    always_comb begin
        o_cls  = NORMAL;
        o_mant = {1'b1, w_frac};
        o_exp  = w_exp;
        if (w_exp == '0) begin
            // Subnormals share the exponent of the smallest normal
            o_cls  = (w_frac == '0) ? ZERO : SUBNORM;
            o_mant = {1'b0, w_frac};
            o_exp  = 5'd1;
        end else if (int'(w_exp) == FP16_EXP_MAX) begin
            o_cls  = (w_frac == '0) ? INF : NAN;
        end
    end

endmodule : fp16_unpack
`default_nettype wire

// File: rtl/fp16_to_fixed.sv
`default_nettype none
// ============================================================================
// Module   : fp16_to_fixed
// Brief    : 2-stage fp16 to saturated signed fixed-point stream converter.
// Revision : 1.0
// ============================================================================
module fp16_to_fixed
    import fp16_pkg::*;
#(
    parameter int OUT_W  = 16,
    parameter int FRAC_W = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    fp16_to_fixed_if.slave   bus
);

    localparam int                 c_WIDE    = OUT_W + 12;
    localparam logic signed [7:0]  c_K_OFF   = 8'(FRAC_W - FP16_BIAS - FP16_FRAC_W);
    localparam logic [c_WIDE-1:0]  c_NEG_MAG = c_WIDE'(1) << (OUT_W - 1);
    localparam logic [c_WIDE-1:0]  c_POS_MAX = c_NEG_MAG - c_WIDE'(1);
    localparam logic [OUT_W-1:0]   c_MAX_OUT = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]   c_MIN_OUT = {1'b1, {(OUT_W-1){1'b0}}};

    fp16_class_t       w_cls;
    logic              w_sign;
    logic [10:0]       w_mant;
    logic [4:0]        w_exp;
    logic signed [7:0] w_k;
    logic              w_s2_adv;
    logic              w_s1_adv;

    logic              r_s1_valid;
    fp16_class_t       r_s1_cls;
    logic              r_s1_sign;
    logic [10:0]       r_s1_mant;
    logic signed [7:0] r_s1_k;

    logic              r_out_valid;
    logic [OUT_W-1:0]  r_out_data;
    logic              r_out_sat;
    logic              r_out_nan;
    logic [15:0]       r_sat_cnt;

    fp16_unpack u_unpack (
        .i_data (bus.in_data),
        .o_cls  (w_cls),
        .o_sign (w_sign),
        .o_mant (w_mant),
        .o_exp  (w_exp)
    );

    assign w_k      = $signed({3'b000, w_exp}) + c_K_OFF;
    assign w_s2_adv = !r_out_valid || bus.out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_cls   <= ZERO;
            r_s1_sign  <= 1'b0;
            r_s1_mant  <= '0;
            r_s1_k     <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_cls  <= w_cls;
                r_s1_sign <= w_sign;
                r_s1_mant <= w_mant;
                r_s1_k    <= w_k;
            end
        end
    end

    // Stage 2: shift/round magnitude, then saturate and apply sign
    logic [6:0]        w_kpos;
    logic [7:0]        w_sh;
    logic [11:0]       w_rnd;
    logic [c_WIDE-1:0] w_mag;
    logic [OUT_W-1:0]  w_mag_lo;
    logic              w_huge;
    logic [OUT_W-1:0]  w_data;
    logic              w_sat;
    logic              w_nan;

    assign w_kpos   = r_s1_k[6:0];
    assign w_sh     = 8'(-r_s1_k);
    assign w_mag_lo = w_mag[OUT_W-1:0];

    always_comb begin
        w_mag  = '0;
        w_huge = 1'b0;
        w_rnd  = '0;
        if (!r_s1_k[7]) begin
            if (int'(w_kpos) >= OUT_W)
                w_huge = |r_s1_mant;
            else
                w_mag = c_WIDE'(r_s1_mant) << w_kpos;
        end else if (w_sh < 8'd12) begin
            // Bit 0 after the shift is the half-LSB: round half away from zero
            w_rnd = {r_s1_mant, 1'b0} >> w_sh[3:0];
            w_mag = c_WIDE'(w_rnd[11:1]) + c_WIDE'(w_rnd[0]);
        end
    end

    always_comb begin
        w_data = '0;
        w_sat  = 1'b0;
        w_nan  = 1'b0;
        case (r_s1_cls)
            NAN: w_nan = 1'b1;
            INF: begin
                w_sat  = 1'b1;
                w_data = r_s1_sign ? c_MIN_OUT : c_MAX_OUT;
            end
            default: begin
                if (r_s1_sign) begin
                    if (w_huge || (w_mag > c_NEG_MAG)) begin
                        w_sat  = 1'b1;
                        w_data = c_MIN_OUT;
                    end else begin
                        w_data = -w_mag_lo;
                    end
                end else begin
                    if (w_huge || (w_mag > c_POS_MAX)) begin
                        w_sat  = 1'b1;
                        w_data = c_MAX_OUT;
                    end else begin
                        w_data = w_mag_lo;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            r_out_nan   <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_data;
                r_out_sat  <= w_sat;
                r_out_nan  <= w_nan;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_cnt <= '0;
        end else if (bus.sat_clr) begin
            r_sat_cnt <= '0;
        end else if (r_out_valid && bus.out_ready && r_out_sat && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign bus.in_ready  = w_s1_adv;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sat   = r_out_sat;
    assign bus.out_nan   = r_out_nan;
    assign bus.sat_cnt   = r_sat_cnt;

endmodule : fp16_to_fixed
`default_nettype wire

// File: tb/tb_fp16_to_fixed.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp16_to_fixed
// Brief    : Directed self-checking bench for fp16_to_fixed (OUT_W=16, FRAC_W=8).
// Revision : 1.0
// ============================================================================
module tb_fp16_to_fixed;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp16_to_fixed_if #(.OUT_W(16)) bus ();

    fp16_to_fixed #(.OUT_W(16), .FRAC_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] din;
        logic [15:0] dout;
        logic        sat;
        logic        nan;
        string       name;
    } vec_t;

    vec_t        vecs[11];
    logic [15:0] bp_in[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One isolated transfer with out_ready high: result must land exactly 2 edges later
    task automatic send_check(input logic [15:0] din, input logic [15:0] dout,
                              input logic sat, input logic nan, input string name);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = din;
        bus.out_ready = 1'b1;
        #1 check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 check({name, "_lat1_valid"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_lat2_valid"}, 32'(bus.out_valid), 32'd1);
        check({name, "_data"}, 32'(bus.out_data), 32'(dout));
        check({name, "_sat"}, 32'(bus.out_sat), 32'(sat));
        check({name, "_nan"}, 32'(bus.out_nan), 32'(nan));
    endtask

    task automatic drain();
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        prev_stall;
        logic [15:0] prev_data;
        int          sent;
        int          rcvd;

        vecs[0]  = '{16'h3C00, 16'h0100, 1'b0, 1'b0, "one"};
        vecs[1]  = '{16'hC100, 16'hFD80, 1'b0, 1'b0, "neg2p5"};
        vecs[2]  = '{16'h1800, 16'h0001, 1'b0, 1'b0, "rnd_2m9"};
        vecs[3]  = '{16'h1400, 16'h0000, 1'b0, 1'b0, "rnd_2m10"};
        vecs[4]  = '{16'h8000, 16'h0000, 1'b0, 1'b0, "neg_zero"};
        vecs[5]  = '{16'h0001, 16'h0000, 1'b0, 1'b0, "min_sub"};
        vecs[6]  = '{16'h5A40, 16'h7FFF, 1'b1, 1'b0, "pos200"};
        vecs[7]  = '{16'hDA40, 16'h8000, 1'b1, 1'b0, "neg200"};
        vecs[8]  = '{16'hD800, 16'h8000, 1'b0, 1'b0, "neg128"};
        vecs[9]  = '{16'h7C00, 16'h7FFF, 1'b1, 1'b0, "pos_inf"};
        vecs[10] = '{16'h7E00, 16'h0000, 1'b0, 1'b1, "nan"};

        bp_in = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500,
                  16'h4600, 16'h4700, 16'h4800, 16'h4880, 16'h4900};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.sat_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_sat", 32'(bus.out_sat), 32'd0);
        check("rst_out_nan", 32'(bus.out_nan), 32'd0);
        check("rst_sat_cnt", 32'(bus.sat_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 11; i++)
            send_check(vecs[i].din, vecs[i].dout, vecs[i].sat, vecs[i].nan, vecs[i].name);
        drain();
        check("sat_cnt_3", 32'(bus.sat_cnt), 32'd3);

        // Clear coincides with a fourth saturated handshake: clear wins
        send_check(16'h7C00, 16'h7FFF, 1'b1, 1'b0, "clr_inf");
        @(negedge clk);
        bus.sat_clr = 1'b1;
        @(posedge clk);
        #1;
        check("clr_cnt", 32'(bus.sat_cnt), 32'd0);
        check("clr_consumed", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        bus.sat_clr = 1'b0;
        @(posedge clk);
        #1 check("clr_cnt_hold", 32'(bus.sat_cnt), 32'd0);

        // Backpressure stream with random out_ready
        sent       = 0;
        rcvd       = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int cyc = 0; cyc < 300 && rcvd < 10; cyc++) begin
            @(negedge clk);
            bus.out_ready = 1'($urandom_range(0, 1));
            if (sent < 10) begin
                bus.in_valid = 1'b1;
                bus.in_data  = bp_in[sent];
            end else begin
                bus.in_valid = 1'b0;
            end
            #4;
            if (prev_stall) begin
                check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
                check("bp_hold_data", 32'(bus.out_data), 32'(prev_data));
            end
            if (bus.out_valid && bus.out_ready) begin
                check("bp_order", 32'(bus.out_data), 32'((rcvd + 1) * 256));
                check("bp_flags", {30'd0, bus.out_sat, bus.out_nan}, 32'd0);
                rcvd++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            if (bus.in_valid && bus.in_ready)
                sent++;
            @(posedge clk);
        end
        check("bp_count", 32'(rcvd), 32'd10);
        drain();
        check("bp_no_dup", 32'(bus.out_valid), 32'd0);

        // Mid-stream reset with two items in flight
        send_check(16'h7C00, 16'h7FFF, 1'b1, 1'b0, "pre_rst");
        drain();
        check("pre_rst_cnt", 32'(bus.sat_cnt), 32'd1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h3C00;
        @(posedge clk);
        @(negedge clk);
        bus.in_data = 16'h4000;
        @(posedge clk);
        #1 check("inflight_valid", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_cnt", 32'(bus.sat_cnt), 32'd0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        #1 check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 check("rst_discard", 32'(bus.out_valid), 32'd0);
        send_check(16'h3C00, 16'h0100, 1'b0, 1'b0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fp16_to_fixed
`default_nettype wire
